xgxs_lane_tx_sequencer: RTL and testbench

- Per-lane XGXS transmit sequencer sitting directly in front of the lane's 8b10b encoder. It drives the encoder's encode_data_in and konstant inputs.
- Runs the lane start-up sync period, then passes MAC column data through.
- Replaces idle control characters with the XAUI idle pattern: /K/ = K28.5, /R/ = K28.0, /A/ = K28.3. /A/ spacing is 16-31 columns; the K/R choice is PRBS-randomised.
- Screens illegal control codes to /E/.

---
 rtl/xgxs_lane_tx_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_xgxs_lane_tx_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgxs_lane_tx_sequencer.sv
// -----------------------------------------------------------------------------
// xgxs_lane_tx_sequencer
//
// Per-lane XGXS transmit sequencer placed directly in front of the lane's
// 8b10b encoder. After reset or an explicit restart it sends a run of /K/
// columns (SYNC). It then passes MAC column data through (RUN).
//
// In RUN, idle columns (ctrl=1, 8'h07) are replaced by the XAUI idle pattern:
//   /A/ = K28.3 (8'h7C), sent every A_MIN + prbs[3:0] columns.
//   /K/ = K28.5 (8'hBC) or /R/ = K28.0 (8'h1C), chosen by a 7-bit PRBS.
// Control codes that are not legal XGXS characters are replaced by
// /E/ (8'hFE), and bad_ctrl_o flags each replacement.
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          synchronous reset, active-high
//   enable_i       lane enable; low forces state OFF
//   force_sync_i   one-cycle pulse; restarts the sync period
//   tx_data_i      MAC lane byte
//   tx_ctrl_i      1 = tx_data_i is a control character
//   enc_data_o     byte to encoder encode_data_in
//   enc_konstant_o to encoder konstant
//   tx_ready_o     high in RUN; input is consumed only while high
//   a_sent_o       pulse, aligned with an /A/ on enc_data_o
//   bad_ctrl_o     pulse, aligned with an /E/ produced by substitution
//   state_o        00 OFF, 01 SYNC, 10 RUN
// -----------------------------------------------------------------------------
module xgxs_lane_tx_sequencer #(
  parameter int unsigned SYNC_COLS = 16,
  parameter int unsigned A_MIN     = 16,
  parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       force_sync_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_ctrl_i,
  output logic [7:0] enc_data_o,
  output logic       enc_konstant_o,
  output logic       tx_ready_o,
  output logic       a_sent_o,
  output logic       bad_ctrl_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_SYNC = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  localparam logic [7:0] CH_K    = 8'hBC;  // K28.5
  localparam logic [7:0] CH_R    = 8'h1C;  // K28.0
  localparam logic [7:0] CH_A    = 8'h7C;  // K28.3
  localparam logic [7:0] CH_E    = 8'hFE;  // K30.7 error
  localparam logic [7:0] CH_IDLE = 8'h07;  // MAC idle control

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COLS - 1);
  localparam logic [4:0] A_BASE    = 5'(A_MIN - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] sync_cnt_q, sync_cnt_d;
  logic [4:0] a_cnt_q, a_cnt_d;
  logic [6:0] prbs_q, prbs_d;
  logic       prev_idle_q, prev_idle_d;
  logic [7:0] enc_data_q, enc_data_d;
  logic       enc_k_q, enc_k_d;
  logic       tx_ready_q, tx_ready_d;
  logic       a_sent_q, a_sent_d;
  logic       bad_ctrl_q, bad_ctrl_d;

  logic       legal_ctrl;

  // Control characters that are forwarded unchanged.
  always_comb begin
    legal_ctrl = 1'b0;
    case (tx_data_i)
      8'hFB, 8'hFD, 8'hFE, 8'h9C, 8'hBC, 8'h7C, 8'h1C: legal_ctrl = 1'b1;
      default:                                         legal_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    a_cnt_d     = a_cnt_q;
    prbs_d      = prbs_q;
    prev_idle_d = prev_idle_q;
    enc_data_d  = CH_K;
    enc_k_d     = 1'b1;
    a_sent_d    = 1'b0;
    bad_ctrl_d  = 1'b0;

    case (state_q)
      ST_OFF: begin
        prev_idle_d = 1'b0;
        if (enable_i) begin
          state_d    = ST_SYNC;
          sync_cnt_d = 8'd0;
        end
      end

      ST_SYNC: begin
        prev_idle_d = 1'b0;
        if (!enable_i) begin
          state_d = ST_OFF;
        end else if (force_sync_i) begin
          sync_cnt_d = 8'd0;
        end else if (sync_cnt_q == SYNC_LAST) begin
          state_d    = ST_RUN;
          sync_cnt_d = 8'd0;
        end else begin
          sync_cnt_d = sync_cnt_q + 8'd1;
        end
      end

      ST_RUN: begin
        // The LFSR and the /A/ countdown run on every RUN column, data or idle.
        prbs_d  = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
        a_cnt_d = (a_cnt_q == 5'd0) ? 5'd0 : a_cnt_q - 5'd1;

        if (!tx_ctrl_i) begin
          enc_data_d  = tx_data_i;
          enc_k_d     = 1'b0;
          prev_idle_d = 1'b0;
        end else if (tx_data_i == CH_IDLE) begin
          prev_idle_d = 1'b1;
          if (a_cnt_q == 5'd0) begin
            enc_data_d = CH_A;
            a_sent_d   = 1'b1;
            a_cnt_d    = A_BASE + {1'b0, prbs_q[3:0]};
          end else if (!prev_idle_q) begin
            // The first idle after a non-idle column must be /K/.
            enc_data_d = CH_K;
          end else begin
            enc_data_d = prbs_q[6] ? CH_K : CH_R;
          end
        end else if (legal_ctrl) begin
          // A raw 7C passed through does not count as a scheduled /A/.
          enc_data_d  = tx_data_i;
          prev_idle_d = 1'b0;
        end else begin
          enc_data_d  = CH_E;
          bad_ctrl_d  = 1'b1;
          prev_idle_d = 1'b0;
        end

        // The column above is still sent under RUN rules; only the
        // next state changes.
        if (!enable_i) begin
          state_d = ST_OFF;
        end else if (force_sync_i) begin
          state_d    = ST_SYNC;
          sync_cnt_d = 8'd0;
        end
      end

      default: begin
        state_d     = ST_SYNC;
        sync_cnt_d  = 8'd0;
        prev_idle_d = 1'b0;
      end
    endcase

    // tx_ready is registered but has to line up with the cycles in which
    // the RUN state consumes input, so it is derived from the next state.
    tx_ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= 8'd0;
      a_cnt_q     <= A_BASE;
      prbs_q      <= PRBS_SEED;
      prev_idle_q <= 1'b0;
      enc_data_q  <= CH_K;
      enc_k_q     <= 1'b1;
      tx_ready_q  <= 1'b0;
      a_sent_q    <= 1'b0;
      bad_ctrl_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      a_cnt_q     <= a_cnt_d;
      prbs_q      <= prbs_d;
      prev_idle_q <= prev_idle_d;
      enc_data_q  <= enc_data_d;
      enc_k_q     <= enc_k_d;
      tx_ready_q  <= tx_ready_d;
      a_sent_q    <= a_sent_d;
      bad_ctrl_q  <= bad_ctrl_d;
    end
  end

  assign enc_data_o     = enc_data_q;
  assign enc_konstant_o = enc_k_q;
  assign tx_ready_o     = tx_ready_q;
  assign a_sent_o       = a_sent_q;
  assign bad_ctrl_o     = bad_ctrl_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_xgxs_lane_tx_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for xgxs_lane_tx_sequencer.
// Sets up the default parameters and drives directed stimulus. It checks the
// DUT against hand-computed table vectors and a small LFSR/idle model.
// -----------------------------------------------------------------------------
module tb_xgxs_lane_tx_sequencer;

  localparam int SYNC_COLS = 16;
  localparam int A_MIN     = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       force_sync;
  logic [7:0] tx_data;
  logic       tx_ctrl;
  logic [7:0] enc_data;
  logic       enc_konstant;
  logic       tx_ready;
  logic       a_sent;
  logic       bad_ctrl;
  logic [1:0] state;

  always #5 clk = ~clk;

  xgxs_lane_tx_sequencer #(
    .SYNC_COLS(SYNC_COLS),
    .A_MIN    (A_MIN),
    .PRBS_SEED(7'h7F)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .force_sync_i  (force_sync),
    .tx_data_i     (tx_data),
    .tx_ctrl_i     (tx_ctrl),
    .enc_data_o    (enc_data),
    .enc_konstant_o(enc_konstant),
    .tx_ready_o    (tx_ready),
    .a_sent_o      (a_sent),
    .bad_ctrl_o    (bad_ctrl),
    .state_o       (state)
  );

  int checks = 0;
  int errors = 0;

  // Reference state for the idle generator.
  logic [6:0] m_prbs;
  logic [4:0] m_acnt;
  logic       m_prev;

  typedef struct {
    logic       ctrl;
    logic [7:0] data;
    logic       use_model;
    logic [7:0] exp_data;
    logic       exp_k;
    logic       exp_bad;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected output for one RUN column. Advances the reference state.
  task automatic model_col(input logic c, input logic [7:0] d,
                           output logic [7:0] ed, output logic ek,
                           output logic ea, output logic eb);
    logic [4:0] nxt_a;
    nxt_a = (m_acnt == 5'd0) ? 5'd0 : m_acnt - 5'd1;
    ea = 1'b0;
    eb = 1'b0;
    ek = 1'b1;
    if (!c) begin
      ed = d;
      ek = 1'b0;
      m_prev = 1'b0;
    end else if (d == 8'h07) begin
      if (m_acnt == 5'd0) begin
        ed = 8'h7C;
        ea = 1'b1;
        nxt_a = 5'(A_MIN - 1) + {1'b0, m_prbs[3:0]};
      end else if (!m_prev) begin
        ed = 8'hBC;
      end else begin
        ed = m_prbs[6] ? 8'hBC : 8'h1C;
      end
      m_prev = 1'b1;
    end else if (d inside {8'hFB, 8'hFD, 8'hFE, 8'h9C, 8'hBC, 8'h7C, 8'h1C}) begin
      ed = d;
      m_prev = 1'b0;
    end else begin
      ed = 8'hFE;
      eb = 1'b1;
      m_prev = 1'b0;
    end
    m_acnt = nxt_a;
    m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
  endtask

  // Drive one RUN column and check the encoder outputs one cycle later.
  // Uses the model expectation when use_model is set, otherwise the table values.
  task automatic run_col(input string tag, input logic c, input logic [7:0] d,
                         input logic use_model, input logic [7:0] td,
                         input logic tk, input logic tbad,
                         output logic [7:0] got_d, output logic got_a);
    logic [7:0] ed;
    logic       ek, ea, eb;
    model_col(c, d, ed, ek, ea, eb);
    if (!use_model) begin
      ed = td;
      ek = tk;
      eb = tbad;
      ea = 1'b0;
    end
    tx_ctrl = c;
    tx_data = d;
    step();
    $display("%s ctrl=%0b data=%02h -> enc=%02h k=%0b a=%0b bad=%0b st=%0d",
             tag, c, d, enc_data, enc_konstant, a_sent, bad_ctrl, state);
    check({tag, "_data"}, enc_data, ed);
    check({tag, "_k"}, enc_konstant, ek);
    check({tag, "_a_sent"}, a_sent, ea);
    check({tag, "_bad"}, bad_ctrl, eb);
    got_d = enc_data;
    got_a = a_sent;
  endtask

  // From SYNC with sync_cnt = 0: SYNC_COLS-1 further SYNC cycles, then RUN.
  // Data input is driven but must be ignored.
  task automatic sync_to_run(input string tag);
    tx_ctrl = 1'b0;
    tx_data = 8'h55;
    for (int e = 1; e < SYNC_COLS; e++) begin
      step();
      check({tag, "_sync_state"}, state, 2'b01);
      check({tag, "_sync_ready"}, tx_ready, 0);
      check({tag, "_sync_enc"}, enc_data, 8'hBC);
      check({tag, "_sync_k"}, enc_konstant, 1);
    end
    step();
    $display("%s enter RUN: st=%0d ready=%0b enc=%02h", tag, state, tx_ready, enc_data);
    check({tag, "_run_state"}, state, 2'b10);
    check({tag, "_run_ready"}, tx_ready, 1);
    check({tag, "_run_enc"}, enc_data, 8'hBC);
  endtask

  initial begin
    logic [7:0] gd;
    logic       ga;
    int         last_a;
    int         n_a;
    int         n_7c;

    vecs[0]  = '{1'b1, 8'hFB, 1'b0, 8'hFB, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hAA, 1'b0, 8'hAA, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hFD, 1'b0, 8'hFD, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 8'hFE, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h9C, 1'b0, 8'h9C, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'hBC, 1'b0, 8'hBC, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h7C, 1'b0, 8'h7C, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'hFE, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h07, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h00, 1'b0, 8'hFE, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0};

    rst        = 1'b1;
    enable     = 1'b1;
    force_sync = 1'b0;
    tx_ctrl    = 1'b1;
    tx_data    = 8'h07;

    // ---- reset state
    step();
    step();
    $display("reset: st=%0d enc=%02h k=%0b ready=%0b", state, enc_data, enc_konstant, tx_ready);
    check("rst_state", state, 2'b01);
    check("rst_enc", enc_data, 8'hBC);
    check("rst_k", enc_konstant, 1);
    check("rst_ready", tx_ready, 0);
    check("rst_a_sent", a_sent, 0);
    check("rst_bad", bad_ctrl, 0);

    // ---- start-up sync period
    rst = 1'b0;
    sync_to_run("init");
    m_prbs = 7'h7F;
    m_acnt = 5'(A_MIN - 1);
    m_prev = 1'b0;

    // ---- continuous idle: bit-exact K/R/A pattern and /A/ spacing
    last_a = -1;
    n_a    = 0;
    n_7c   = 0;
    for (int i = 0; i < 200; i++) begin
      run_col("idle", 1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0, gd, ga);
      check("idle_set", int'(gd inside {8'hBC, 8'h1C, 8'h7C}), 1);
      if (gd == 8'h7C) n_7c++;
      if (ga) begin
        n_a++;
        if (last_a >= 0)
          check("a_gap_range", int'((i - last_a) >= 16 && (i - last_a) <= 31), 1);
        last_a = i;
      end
    end
    check("a_count_vs_7c", n_a, n_7c);
    check("a_count_nonzero", int'(n_a >= 6), 1);

    // ---- table vectors: data burst, pass-through, illegal codes
    for (int v = 0; v < 16; v++) begin
      run_col($sformatf("vec%0d", v), vecs[v].ctrl, vecs[v].data, vecs[v].use_model,
              vecs[v].exp_data, vecs[v].exp_k, vecs[v].exp_bad, gd, ga);
      if (v == 4)
        check("first_idle_after_data", int'(gd == 8'hBC || (gd == 8'h7C && ga)), 1);
    end

    // ---- force_sync mid-RUN: column still RUN-encoded, then SYNC restarts
    force_sync = 1'b1;
    run_col("force", 1'b1, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, gd, ga);
    force_sync = 1'b0;
    check("force_state", state, 2'b01);
    check("force_ready", tx_ready, 0);
    tx_ctrl = 1'b0;
    tx_data = 8'h55;
    for (int e = 1; e < SYNC_COLS; e++) begin
      step();
      check("fs_sync_state", state, 2'b01);
      check("fs_sync_enc", enc_data, 8'hBC);
    end
    // sync_cnt is now at its last value; disable must win over expiry.
    enable = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      $display("off%0d: st=%0d enc=%02h k=%0b ready=%0b", e, state, enc_data, enc_konstant, tx_ready);
      check("off_state", state, 2'b00);
      check("off_enc", enc_data, 8'hBC);
      check("off_k", enc_konstant, 1);
      check("off_ready", tx_ready, 0);
    end
    enable = 1'b1;
    step();
    check("reen_state", state, 2'b01);
    sync_to_run("reen");
    m_prev = 1'b0;
    for (int i = 0; i < 40; i++)
      run_col("reidle", 1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0, gd, ga);

    // ---- reset mid-RUN for one cycle
    rst     = 1'b1;
    tx_ctrl = 1'b1;
    tx_data = 8'h07;
    step();
    rst = 1'b0;
    $display("midrst: st=%0d enc=%02h ready=%0b", state, enc_data, tx_ready);
    check("midrst_state", state, 2'b01);
    check("midrst_enc", enc_data, 8'hBC);
    check("midrst_ready", tx_ready, 0);
    check("midrst_a_sent", a_sent, 0);
    sync_to_run("post_rst");
    m_prbs = 7'h7F;
    m_acnt = 5'(A_MIN - 1);
    m_prev = 1'b0;
    for (int i = 0; i < 40; i++)
      run_col("seeded", 1'b1, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0, gd, ga);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
